curl_host_seq: RTL and testbench

Host-side sequencer for the Curl transform unit: the initiator end of the curl hash interface. It packs a stream of `WORD_W`-bit input words into two `HASH_LENGTH`-bit hash parts, presents them with the first/second part strobes, and waits for `curl_transform_finish`. It then captures the `2*HASH_LENGTH`-bit result and streams it back out as `WORD_W`-bit words. It sits between the host bus adapter and the Curl calculation unit.

---
 rtl/curl_host_seq_if.sv | 41 ++++
 rtl/curl_host_seq.sv | 188 ++++++++++++++++++
 tb/tb_curl_host_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/curl_host_seq_if.sv
// curl_host_seq_if: stream-in, Curl hash handshake and stream-out signals of
// the Curl host sequencer, bundled so the sequencer and its environment share
// one definition. The master modport is the sequencer side.
interface curl_host_seq_if #(
  parameter int HASH_LENGTH = 486,
  parameter int WORD_W      = 54
);
  logic [WORD_W-1:0]        s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [HASH_LENGTH-1:0]   curl_in_hash;
  logic                     curl_first_part_hash;
  logic                     curl_second_part_hash;
  logic                     curl_transform_finish;
  logic [2*HASH_LENGTH-1:0] curl_out_hash;
  logic [WORD_W-1:0]        m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     busy;
  logic                     err;

  modport master (
    input  s_data, s_valid,
    output s_ready,
    output curl_in_hash, curl_first_part_hash, curl_second_part_hash,
    input  curl_transform_finish, curl_out_hash,
    output m_data, m_valid,
    input  m_ready,
    output busy, err
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready,
    input  curl_in_hash, curl_first_part_hash, curl_second_part_hash,
    output curl_transform_finish, curl_out_hash,
    input  m_data, m_valid,
    output m_ready,
    input  busy, err
  );
endinterface

// File: rtl/curl_host_seq.sv
// curl_host_seq: initiator end of the Curl hash interface. Packs WORD_W-bit
// input words into two HASH_LENGTH-bit hash parts, strobes them into the Curl
// unit, waits for the finish pulse, then streams the 2*HASH_LENGTH-bit result
// back out one WORD_W-bit word at a time.
// Optional feature: define CURL_SEQ_TIMEOUT_EN to build the WAIT watchdog that
// sets the sticky err flag and drops the message after TIMEOUT_CYCLES cycles.
module curl_host_seq #(
  parameter int HASH_LENGTH    = 486,
  parameter int WORD_W         = 54,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            arst,
  curl_host_seq_if.master bus
);

  localparam int N     = HASH_LENGTH / WORD_W;
  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(2 * N - 1);

  if (HASH_LENGTH % WORD_W != 0) begin : g_bad_word_w
    $error("curl_host_seq: HASH_LENGTH must be a multiple of WORD_W");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("curl_host_seq: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_FILL1,
    ST_LOAD1,
    ST_FILL2,
    ST_LOAD2,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         word_cnt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic [HASH_LENGTH-1:0]   asm_q;
  logic [2*HASH_LENGTH-1:0] result_q;
  logic                     first_q;
  logic                     second_q;
  logic                     m_valid_q;
  logic [WORD_W-1:0]        m_data_q;
  logic                     busy_q;
  logic                     s_fire;
  logic                     capture;
  logic                     expire;

  assign bus.s_ready = (state == ST_FILL1) || (state == ST_FILL2);
  assign s_fire      = bus.s_ready && bus.s_valid;
  assign capture     = (state == ST_WAIT) && bus.curl_transform_finish;
  assign cnt_nxt     = word_cnt + 1'b1;

`ifdef CURL_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // A finish pulse on the limit cycle takes priority over the timeout.
  assign expire = (state == ST_WAIT) && !bus.curl_transform_finish &&
                  (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count WAIT cycles, latch err when the limit passes unanswered.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != ST_WAIT) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign expire  = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Sequencer FSM with registered strobes, busy and result-stream outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= ST_FILL1;
      word_cnt  <= '0;
      first_q   <= 1'b0;
      second_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      first_q  <= 1'b0;
      second_q <= 1'b0;
      case (state)
        ST_FILL1: begin
          if (s_fire) begin
            if (word_cnt == LAST_IN) begin
              state    <= ST_LOAD1;
              word_cnt <= '0;
              first_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              word_cnt <= cnt_nxt;
            end
          end
        end
        ST_LOAD1: begin
          state <= ST_FILL2;
        end
        ST_FILL2: begin
          if (s_fire) begin
            if (word_cnt == LAST_IN) begin
              state    <= ST_LOAD2;
              word_cnt <= '0;
              second_q <= 1'b1;
            end else begin
              word_cnt <= cnt_nxt;
            end
          end
        end
        ST_LOAD2: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.curl_transform_finish) begin
            state     <= ST_DRAIN;
            m_valid_q <= 1'b1;
            m_data_q  <= bus.curl_out_hash[WORD_W-1:0];
          end else if (expire) begin
            state  <= ST_FILL1;
            busy_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (bus.m_ready) begin
            if (word_cnt == LAST_OUT) begin
              state     <= ST_FILL1;
              word_cnt  <= '0;
              m_valid_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              word_cnt <= cnt_nxt;
              m_data_q <= result_q[cnt_nxt*WORD_W +: WORD_W];
            end
          end
        end
        default: begin
          state    <= ST_FILL1;
          word_cnt <= '0;
        end
      endcase
    end
  end

  // Assembly register: each accepted word lands in its slot, word 0 at the LSBs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      asm_q <= '0;
    end else if (s_fire) begin
      asm_q[word_cnt*WORD_W +: WORD_W] <= bus.s_data;
    end
  end

  // Result register: captures the transform output on the finish pulse in WAIT.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      result_q <= '0;
    end else if (capture) begin
      result_q <= bus.curl_out_hash;
    end
  end

  assign bus.curl_in_hash          = asm_q;
  assign bus.curl_first_part_hash  = first_q;
  assign bus.curl_second_part_hash = second_q;
  assign bus.m_valid               = m_valid_q;
  assign bus.m_data                = m_data_q;
  assign bus.busy                  = busy_q;

endmodule

// File: tb/tb_curl_host_seq.sv
// tb_curl_host_seq: randomized bench for curl_host_seq. The reference view is
// the message itself: the expected hash parts are the input words laid out
// word 0 at the LSBs, the expected output stream is the result words in order.
module tb_curl_host_seq;

  localparam int HL = 486;
  localparam int WW = 54;
  localparam int NW = HL / WW;

  logic clk;
  logic arst;
  int   n_total;
  int   n_bad;
  bit   gaps;
  logic exp_err;

  logic [WW-1:0] in_words  [2*NW];
  logic [WW-1:0] res_words [2*NW];

  curl_host_seq_if #(.HASH_LENGTH(HL), .WORD_W(WW)) bus ();

  curl_host_seq #(
    .HASH_LENGTH   (HL),
    .WORD_W        (WW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] r54();
    return WW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [2*HL-1:0] rand_out();
    logic [2*HL-1:0] g;
    for (int k = 0; k < 2 * NW; k++) g[k*WW +: WW] = r54();
    return g;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 2 * NW; k++) begin
      in_words[k]  = r54();
      res_words[k] = r54();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete message: feed, strobe checks, Curl response, drain.
  // rmode: 0 m_ready always 1, 1 alternating starting at 0, 2 random.
  task automatic run_msg(input int lat, input int rmode, input int abort_after,
                         input bit spur, input bit no_finish);
    int idx;
    int guard;
    int wcyc;
    int oidx;
    int dcyc;
    bit fire;
    bit gap_seen;
    logic [HL-1:0]   p1;
    logic [HL-1:0]   p2;
    logic [2*HL-1:0] rh;
    for (int k = 0; k < NW; k++) begin
      p1[k*WW +: WW] = in_words[k];
      p2[k*WW +: WW] = in_words[NW + k];
    end
    for (int k = 0; k < 2 * NW; k++) rh[k*WW +: WW] = res_words[k];

    if (spur) begin
      bus.curl_transform_finish = 1'b1;
      bus.curl_out_hash = rand_out();
    end
    idx = 0;
    guard = 0;
    gap_seen = 1'b0;
    while (idx < 2 * NW) begin
      bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_data  = bus.s_valid ? in_words[idx] : r54();
      fire = bus.s_valid && bus.s_ready;
      tick();
      bus.curl_transform_finish = 1'b0;
      if (gap_seen) begin
        chk("ready_after_gap", bus.s_ready, 1'b1);
        gap_seen = 1'b0;
      end
      if (fire) idx++;
      chk("first_stb", bus.curl_first_part_hash, fire && idx == NW);
      chk("second_stb", bus.curl_second_part_hash, fire && idx == 2 * NW);
      chk("m_valid_fill", bus.m_valid, 1'b0);
      if (fire && idx == NW) begin
        chk("hash_part1", bus.curl_in_hash, p1);
        chk("ready_gap", bus.s_ready, 1'b0);
        chk("busy_load1", bus.busy, 1'b1);
        gap_seen = 1'b1;
      end
      if (fire && idx == 2 * NW) chk("hash_part2", bus.curl_in_hash, p2);
      guard++;
      if (guard > 400) begin
        chk("feed_bound", 32'(idx), 32'(2 * NW));
        bus.s_valid = 1'b0;
        return;
      end
    end
    bus.s_valid = 1'b0;
    // Observing LOAD2 now; a finish pulse here must be ignored.
    if (spur) begin
      bus.curl_transform_finish = 1'b1;
      bus.curl_out_hash = rand_out();
    end
    tick();
    bus.curl_transform_finish = 1'b0;
    chk("ready_wait", bus.s_ready, 1'b0);

    if (no_finish) begin
      wcyc = 0;
      while (bus.busy && wcyc < 100) begin
        tick();
        wcyc++;
      end
      chk("timeout_cycles", 32'(wcyc), 32'd16);
      chk("timeout_err", bus.err, 1'b1);
      chk("timeout_ready", bus.s_ready, 1'b1);
      chk("timeout_m_valid", bus.m_valid, 1'b0);
      exp_err = 1'b1;
      return;
    end

    for (int k = 0; k < lat; k++) begin
      chk("m_valid_wait", bus.m_valid, 1'b0);
      tick();
    end
    chk("busy_wait", bus.busy, 1'b1);
    chk("m_valid_wait", bus.m_valid, 1'b0);
    bus.curl_transform_finish = 1'b1;
    bus.curl_out_hash = rh;
    tick();
    bus.curl_transform_finish = 1'b0;
    bus.curl_out_hash = rand_out();
    chk("m_valid_rise", bus.m_valid, 1'b1);

    oidx = 0;
    dcyc = 0;
    while (oidx < 2 * NW && dcyc < 200) begin
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = dcyc[0];
        default: bus.m_ready = $urandom_range(0, 1) != 0;
      endcase
      chk("m_valid_drain", bus.m_valid, 1'b1);
      chk("m_data", bus.m_data, res_words[oidx]);
      fire = bus.m_valid && bus.m_ready;
      tick();
      dcyc++;
      if (fire) oidx++;
      if (abort_after >= 0 && oidx == abort_after) begin
        #2 arst = 1'b1;
        #1;
        chk("rst_drain_m_valid", bus.m_valid, 1'b0);
        chk("rst_drain_m_data", bus.m_data, '0);
        chk("rst_drain_busy", bus.busy, 1'b0);
        bus.m_ready = 1'b0;
        tick();
        arst = 1'b0;
        return;
      end
    end
    bus.m_ready = 1'b0;
    chk("drain_words", 32'(oidx), 32'(2 * NW));
    if (rmode == 0) chk("drain_cycles", 32'(dcyc), 32'(2 * NW));
    if (rmode == 1) chk("drain_cycles_bp", 32'(dcyc), 32'(4 * NW));
    chk("end_m_valid", bus.m_valid, 1'b0);
    chk("end_ready", bus.s_ready, 1'b1);
    chk("end_busy", bus.busy, 1'b0);
    chk("end_err", bus.err, exp_err);
  endtask

  initial begin
    int cnt;
    bit fire;
    n_total = 0;
    n_bad   = 0;
    exp_err = 1'b0;
    gaps    = 1'b1;
    arst    = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.curl_transform_finish = 1'b0;
    bus.curl_out_hash = '0;
    bus.m_ready = 1'b0;
    tick();
    tick();
    chk("rst_s_ready", bus.s_ready, 1'b1);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_data", bus.m_data, '0);
    chk("rst_in_hash", bus.curl_in_hash, '0);
    chk("rst_first", bus.curl_first_part_hash, 1'b0);
    chk("rst_second", bus.curl_second_part_hash, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    arst = 1'b0;
    tick();

    // Directed single message: words 1..18, results 0x100..0x111.
    for (int k = 0; k < 2 * NW; k++) begin
      in_words[k]  = WW'(k + 1);
      res_words[k] = WW'(32'h100 + k);
    end
    gaps = 1'b0;
    run_msg(10, 0, -1, 1'b0, 1'b0);
    gaps = 1'b1;

    // Backpressure with alternating m_ready.
    fill_random();
    run_msg($urandom_range(0, 12), 1, -1, 1'b0, 1'b0);

    // Spurious finish pulses in FILL1 and LOAD2.
    fill_random();
    run_msg($urandom_range(0, 12), 2, -1, 1'b1, 1'b0);

    // Finish on the watchdog limit cycle, then best-case latency.
    fill_random();
    run_msg(15, 0, -1, 1'b0, 1'b0);
    fill_random();
    run_msg(0, 2, -1, 1'b1, 1'b0);

    // Reset in the middle of FILL2.
    fill_random();
    cnt = 0;
    bus.s_valid = 1'b1;
    while (cnt < NW + 3) begin
      bus.s_data = in_words[cnt];
      fire = bus.s_valid && bus.s_ready;
      tick();
      if (fire) cnt++;
    end
    bus.s_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1'b1);
    #2 arst = 1'b1;
    #1;
    chk("rst_fill2_s_ready", bus.s_ready, 1'b1);
    chk("rst_fill2_in_hash", bus.curl_in_hash, '0);
    chk("rst_fill2_busy", bus.busy, 1'b0);
    chk("rst_fill2_m_valid", bus.m_valid, 1'b0);
    chk("rst_fill2_first", bus.curl_first_part_hash, 1'b0);
    tick();
    arst = 1'b0;
    tick();
    chk("rel_s_ready", bus.s_ready, 1'b1);
    chk("rel_busy", bus.busy, 1'b0);
    fill_random();
    run_msg($urandom_range(0, 12), 2, -1, 1'b0, 1'b0);

    // Reset in DRAIN after 5 words, then a clean message from word 0.
    fill_random();
    run_msg(3, 0, 5, 1'b0, 1'b0);
    chk("after_drain_rst_ready", bus.s_ready, 1'b1);
    fill_random();
    run_msg($urandom_range(0, 12), 0, -1, 1'b0, 1'b0);

`ifdef CURL_SEQ_TIMEOUT_EN
    // Watchdog: no finish pulse, then a normal message with err still set.
    fill_random();
    run_msg(0, 0, -1, 1'b0, 1'b1);
    fill_random();
    run_msg($urandom_range(0, 12), 2, -1, 1'b0, 1'b0);
`endif

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_msg($urandom_range(0, 15), $urandom_range(0, 2), -1,
              $urandom_range(0, 1) != 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
